// File: rtl/fp_unpack.sv
// fp_unpack: splits a packed IEEE-754-style word into sign, a signed biased
// exponent and a mantissa with an explicit hidden bit. Subnormal inputs are
// normalized serially (one left shift per cycle), so a non-zero mantissa
// always leaves this block with its MSB set.
module fp_unpack #(
   parameter int MANT_W = 24,
   parameter int EXP_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [EXP_W+MANT_W-1:0]  in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_sign,
   output logic signed [EXP_W:0]    out_exp,
   output logic [MANT_W-1:0]        out_mant,
   output logic                     out_zero,
   output logic                     out_inf,
   output logic                     out_nan,
   output logic                     out_subnormal
);

   localparam int W = EXP_W + MANT_W;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_NORM = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Exponent constants in the signed [EXP_W:0] biased form
   localparam logic signed [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
   localparam logic signed [EXP_W:0] EXP_ONE = (EXP_W+1)'(1);
   localparam logic signed [EXP_W:0] EXP_ZERO = '0;

   logic [1:0]              state_q, state_d;
   logic                    sign_q, sign_d;
   logic signed [EXP_W:0]   exp_q, exp_d;
   logic [MANT_W-1:0]       mant_q, mant_d;
   logic                    zero_q, zero_d;
   logic                    inf_q, inf_d;
   logic                    nan_q, nan_d;
   logic                    sub_q, sub_d;

   // Packed input fields
   logic                    in_sign;
   logic [EXP_W-1:0]        in_e;
   logic [MANT_W-2:0]       in_f;
   logic                    accept;

   assign in_sign = in_data[W-1];
   assign in_e    = in_data[W-2 -: EXP_W];
   assign in_f    = in_data[MANT_W-2:0];

   // A finished result may be replaced by a new word on the same edge it is taken
   assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
   assign accept   = in_valid && in_ready;

   assign out_valid     = (state_q == S_DONE);
   assign out_sign      = sign_q;
   assign out_exp       = exp_q;
   assign out_mant      = mant_q;
   assign out_zero      = zero_q;
   assign out_inf       = inf_q;
   assign out_nan       = nan_q;
   assign out_subnormal = sub_q;

   // Next-state: normalization shift, handshake retirement, and classification on accept
   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      exp_d   = exp_q;
      mant_d  = mant_q;
      zero_d  = zero_q;
      inf_d   = inf_q;
      nan_d   = nan_q;
      sub_d   = sub_q;

      case (state_q)
         S_NORM: begin
            // The bit below the MSB becomes the MSB after this shift
            mant_d = mant_q << 1;
            exp_d  = exp_q - EXP_ONE;
            if (mant_q[MANT_W-2]) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready && !accept) begin
               state_d = S_IDLE;
            end
         end
         default: ;
      endcase

      if (accept) begin
         sign_d = in_sign;
         zero_d = 1'b0;
         inf_d  = 1'b0;
         nan_d  = 1'b0;
         sub_d  = 1'b0;
         if (in_e == {EXP_W{1'b1}}) begin
            exp_d   = EXP_MAX;
            mant_d  = {1'b1, in_f};
            nan_d   = |in_f;
            inf_d   = ~|in_f;
            state_d = S_DONE;
         end else if (in_e == '0) begin
            if (in_f == '0) begin
               exp_d   = EXP_ZERO;
               mant_d  = '0;
               zero_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               // Subnormal: start at exponent 1 with no hidden bit, then shift up
               exp_d   = EXP_ONE;
               mant_d  = {1'b0, in_f};
               sub_d   = 1'b1;
               state_d = S_NORM;
            end
         end else begin
            exp_d   = {1'b0, in_e};
            mant_d  = {1'b1, in_f};
            state_d = S_DONE;
         end
      end
   end

   // State and result registers; reset discards any word in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sign_q  <= 1'b0;
         exp_q   <= '0;
         mant_q  <= '0;
         zero_q  <= 1'b0;
         inf_q   <= 1'b0;
         nan_q   <= 1'b0;
         sub_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         exp_q   <= exp_d;
         mant_q  <= mant_d;
         zero_q  <= zero_d;
         inf_q   <= inf_d;
         nan_q   <= nan_d;
         sub_q   <= sub_d;
      end
   end

endmodule
